// File: rtl/jtkiwi_pkg.sv
// Shared types for the graphics-ROM arbiter: FSM encoding, requester indices
// and the round-robin pick rule.
package jtkiwi_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_GUARD = 2'd1,
    ST_WAIT  = 2'd2
  } arb_state_e;

  localparam logic REQ_OBJ = 1'b0;
  localparam logic REQ_SCR = 1'b1;

  // Returns 1 when the tile engine wins; on a tie the one not served last wins.
  function automatic logic rr_pick_scr(input logic pend_obj, input logic pend_scr,
                                       input logic last);
    return pend_scr & (~pend_obj | (last == REQ_OBJ));
  endfunction

endpackage

// File: rtl/jtkiwi_gfx_arb_if.sv
// Bundle of the two draw-engine ROM ports plus the shared SDRAM ROM port.
interface jtkiwi_gfx_arb_if #(
  parameter int AW = 18,
  parameter int DW = 32
);
  logic [AW-1:0] obj_addr;
  logic          obj_cs;
  logic          obj_ok;
  logic [DW-1:0] obj_data;
  logic [AW-1:0] scr_addr;
  logic          scr_cs;
  logic          scr_ok;
  logic [DW-1:0] scr_data;
  logic [AW-1:0] rom_addr;
  logic          rom_cs;
  logic          rom_ok;
  logic [DW-1:0] rom_data;

  // Arbiter side.
  modport slave (
    input  obj_addr, obj_cs, scr_addr, scr_cs, rom_ok, rom_data,
    output obj_ok, obj_data, scr_ok, scr_data, rom_addr, rom_cs
  );

  // Engines and SDRAM side.
  modport master (
    output obj_addr, obj_cs, scr_addr, scr_cs, rom_ok, rom_data,
    input  obj_ok, obj_data, scr_ok, scr_data, rom_addr, rom_cs
  );
endinterface

// File: rtl/jtkiwi_arb_slot.sv
// Per-requester state: registered read data, sticky ok flag and the address
// it was served with, so a held request keeps reading as complete.
module jtkiwi_arb_slot #(
  parameter int AW = 18,
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cs_i,
  input  logic [AW-1:0] addr_i,
  input  logic          done_i,
  input  logic [AW-1:0] srv_addr_i,
  input  logic [DW-1:0] rom_data_i,
  output logic          ok_o,
  output logic [DW-1:0] data_o,
  output logic          pend_o
);

  logic          ok_q, ok_d;
  logic [DW-1:0] data_q, data_d;
  logic [AW-1:0] served_q, served_d;

  always_comb begin
    ok_d     = ok_q;
    data_d   = data_q;
    served_d = served_q;
    if (done_i) begin
      ok_d     = 1'b1;
      data_d   = rom_data_i;
      served_d = srv_addr_i;
    end else if (!cs_i || (addr_i != served_q)) begin
      ok_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ok_q     <= 1'b0;
      data_q   <= '0;
      served_q <= '0;
    end else begin
      ok_q     <= ok_d;
      data_q   <= data_d;
      served_q <= served_d;
    end
  end

  assign ok_o   = ok_q;
  assign data_o = data_q;
  assign pend_o = cs_i & ~ok_q;

endmodule

// File: rtl/jtkiwi_gfx_arb.sv
// Round-robin arbiter sharing one SDRAM graphics-ROM slot between the object
// and tile draw engines, one outstanding access at a time.
module jtkiwi_gfx_arb
  import jtkiwi_pkg::*;
#(
  parameter int AW = 18,
  parameter int DW = 32
) (
  input  logic             clk,
  input  logic             rst,
  jtkiwi_gfx_arb_if.slave  bus
);

  arb_state_e    state_q, state_d;
  logic          gnt_q, gnt_d;
  logic          last_q, last_d;
  logic          rom_cs_q, rom_cs_d;
  logic [AW-1:0] rom_addr_q, rom_addr_d;

  logic          pend_obj, pend_scr, pick_scr, any_pend;
  logic          gnt_cs, oth_pend, in_wait, addr_moved;
  logic [AW-1:0] gnt_addr;
  logic          abort, readdr, done;

  assign any_pend   = pend_obj | pend_scr;
  assign pick_scr   = rr_pick_scr(pend_obj, pend_scr, last_q);
  assign gnt_cs     = (gnt_q == REQ_SCR) ? bus.scr_cs   : bus.obj_cs;
  assign gnt_addr   = (gnt_q == REQ_SCR) ? bus.scr_addr : bus.obj_addr;
  assign oth_pend   = (gnt_q == REQ_SCR) ? pend_obj     : pend_scr;
  assign in_wait    = (state_q == ST_WAIT);
  assign addr_moved = (gnt_addr != rom_addr_q);

  // A dropped request beats everything; a moved address beats rom_ok, which
  // still belongs to the old address.
  assign abort  = in_wait & ~gnt_cs;
  assign readdr = in_wait & gnt_cs & addr_moved;
  assign done   = in_wait & gnt_cs & ~addr_moved & bus.rom_ok;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      gnt_q      <= REQ_OBJ;
      last_q     <= REQ_SCR;
      rom_cs_q   <= 1'b0;
      rom_addr_q <= '0;
    end else begin
      state_q    <= state_d;
      gnt_q      <= gnt_d;
      last_q     <= last_d;
      rom_cs_q   <= rom_cs_d;
      rom_addr_q <= rom_addr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (any_pend) state_d = ST_GUARD;
      ST_GUARD: state_d = ST_WAIT;
      ST_WAIT: begin
        if (abort || done) state_d = ST_IDLE;
        else if (readdr)   state_d = ST_GUARD;
      end
      default:  state_d = ST_IDLE;
    endcase
  end

  // Keeping rom_cs high across a completion avoids a gap when the other side waits.
  always_comb begin
    gnt_d      = gnt_q;
    last_d     = last_q;
    rom_cs_d   = rom_cs_q;
    rom_addr_d = rom_addr_q;
    case (state_q)
      ST_IDLE: begin
        rom_cs_d = any_pend;
        if (any_pend) begin
          gnt_d      = pick_scr;
          rom_addr_d = pick_scr ? bus.scr_addr : bus.obj_addr;
        end
      end
      ST_WAIT: begin
        if (abort) begin
          rom_cs_d = oth_pend;
        end else if (readdr) begin
          rom_addr_d = gnt_addr;
        end else if (done) begin
          rom_cs_d = oth_pend;
          last_d   = gnt_q;
        end
      end
      default: ;
    endcase
  end

  jtkiwi_arb_slot #(.AW(AW), .DW(DW)) u_obj (
    .clk        (clk),
    .rst        (rst),
    .cs_i       (bus.obj_cs),
    .addr_i     (bus.obj_addr),
    .done_i     (done & (gnt_q == REQ_OBJ)),
    .srv_addr_i (rom_addr_q),
    .rom_data_i (bus.rom_data),
    .ok_o       (bus.obj_ok),
    .data_o     (bus.obj_data),
    .pend_o     (pend_obj)
  );

  jtkiwi_arb_slot #(.AW(AW), .DW(DW)) u_scr (
    .clk        (clk),
    .rst        (rst),
    .cs_i       (bus.scr_cs),
    .addr_i     (bus.scr_addr),
    .done_i     (done & (gnt_q == REQ_SCR)),
    .srv_addr_i (rom_addr_q),
    .rom_data_i (bus.rom_data),
    .ok_o       (bus.scr_ok),
    .data_o     (bus.scr_data),
    .pend_o     (pend_scr)
  );

  assign bus.rom_cs   = rom_cs_q;
  assign bus.rom_addr = rom_addr_q;

endmodule

// File: tb/tb_jtkiwi_gfx_arb.sv
// Bench for jtkiwi_gfx_arb: directed vector table, hand-written corner
// sequences, then random requesters against a stale-ok SDRAM responder.
module tb_jtkiwi_gfx_arb;
  localparam int AW = 18;
  localparam int DW = 32;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  jtkiwi_gfx_arb_if #(.AW(AW), .DW(DW)) bus ();
  jtkiwi_gfx_arb #(.AW(AW), .DW(DW)) dut (.clk(clk), .rst(rst), .bus(bus.slave));

  int n_pass = 0;
  int n_tot  = 0;

  typedef struct {
    logic          ocs;  logic [AW-1:0] oad;
    logic          scs;  logic [AW-1:0] sad;
    logic          rok;  logic [DW-1:0] rdat;
    logic          ecs;  logic [AW-1:0] ead;
    logic          eook; logic [DW-1:0] eod;
    logic          esok; logic [DW-1:0] esd;
  } vec_t;

  vec_t tv[$];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, required %0h", nm, act, exp);
  endtask

  function automatic logic [DW-1:0] mem(input logic [AW-1:0] a);
    return {~a[13:0], a};
  endfunction

  function automatic vec_t mkv(input logic ocs, input logic [AW-1:0] oad,
                               input logic scs, input logic [AW-1:0] sad,
                               input logic rok, input logic [DW-1:0] rdat,
                               input logic ecs, input logic [AW-1:0] ead,
                               input logic eook, input logic [DW-1:0] eod,
                               input logic esok, input logic [DW-1:0] esd);
    vec_t v;
    v.ocs = ocs; v.oad = oad; v.scs = scs; v.sad = sad; v.rok = rok; v.rdat = rdat;
    v.ecs = ecs; v.ead = ead; v.eook = eook; v.eod = eod; v.esok = esok; v.esd = esd;
    return v;
  endfunction

  task automatic drive(input logic ocs, input logic [AW-1:0] oad, input logic scs,
                       input logic [AW-1:0] sad, input logic rok, input logic [DW-1:0] rdat);
    bus.obj_cs = ocs; bus.obj_addr = oad;
    bus.scr_cs = scs; bus.scr_addr = sad;
    bus.rom_ok = rok; bus.rom_data = rdat;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_rom_cs"},   bus.rom_cs,   1'b0);
    chk({tag, "_rom_addr"}, bus.rom_addr, '0);
    chk({tag, "_obj_ok"},   bus.obj_ok,   1'b0);
    chk({tag, "_obj_data"}, bus.obj_data, '0);
    chk({tag, "_scr_ok"},   bus.scr_ok,   1'b0);
    chk({tag, "_scr_data"}, bus.scr_data, '0);
  endtask

  // Random-phase state: one record per requester (0 = obj, 1 = scr).
  logic          act[2], served[2], clr[2];
  int            age[2], cool[2];
  logic [AW-1:0] adr[2];
  logic          s_ok[2];
  logic [DW-1:0] s_dat[2];
  logic [AW-1:0] prev_addr;

  initial begin
    drive(0, '0, 0, '0, 0, '0);
    repeat (2) @(posedge clk);
    #1;
    chk_all_zero("reset");
    rst = 1'b0;

    // Single obj request, stale ok on scr, then a tie with last-served = scr.
    tv.push_back(mkv(1, 18'h1234, 0, 0, 0, 0,             1, 18'h1234, 0, 0, 0, 0));
    tv.push_back(mkv(1, 18'h1234, 0, 0, 0, 0,             1, 18'h1234, 0, 0, 0, 0));
    tv.push_back(mkv(1, 18'h1234, 0, 0, 1, 32'hDEADBEEF,  0, 18'h1234, 1, 32'hDEADBEEF, 0, 0));
    tv.push_back(mkv(1, 18'h1234, 0, 0, 0, 0,             0, 18'h1234, 1, 32'hDEADBEEF, 0, 0));
    tv.push_back(mkv(0, 18'h1234, 0, 0, 0, 0,             0, 18'h1234, 0, 32'hDEADBEEF, 0, 0));
    tv.push_back(mkv(0, 0, 1, 18'h0040, 1, 32'hCAFE0040,  1, 18'h0040, 0, 32'hDEADBEEF, 0, 0));
    tv.push_back(mkv(0, 0, 1, 18'h0040, 1, 32'hCAFE0040,  1, 18'h0040, 0, 32'hDEADBEEF, 0, 0));
    tv.push_back(mkv(0, 0, 1, 18'h0040, 1, 32'hCAFE0040,  0, 18'h0040, 0, 32'hDEADBEEF, 1, 32'hCAFE0040));
    tv.push_back(mkv(0, 0, 0, 18'h0040, 0, 0,             0, 18'h0040, 0, 32'hDEADBEEF, 0, 32'hCAFE0040));
    tv.push_back(mkv(1, 18'h0010, 1, 18'h0020, 0, 0,      1, 18'h0010, 0, 32'hDEADBEEF, 0, 32'hCAFE0040));
    tv.push_back(mkv(1, 18'h0010, 1, 18'h0020, 0, 0,      1, 18'h0010, 0, 32'hDEADBEEF, 0, 32'hCAFE0040));
    tv.push_back(mkv(1, 18'h0010, 1, 18'h0020, 1, 32'h11111111, 1, 18'h0010, 1, 32'h11111111, 0, 32'hCAFE0040));
    tv.push_back(mkv(1, 18'h0010, 1, 18'h0020, 0, 0,      1, 18'h0020, 1, 32'h11111111, 0, 32'hCAFE0040));
    tv.push_back(mkv(1, 18'h0010, 1, 18'h0020, 0, 0,      1, 18'h0020, 1, 32'h11111111, 0, 32'hCAFE0040));
    tv.push_back(mkv(1, 18'h0010, 1, 18'h0020, 1, 32'h22222222, 0, 18'h0020, 1, 32'h11111111, 1, 32'h22222222));
    tv.push_back(mkv(0, 18'h0010, 0, 18'h0020, 0, 0,      0, 18'h0020, 0, 32'h11111111, 0, 32'h22222222));

    for (int i = 0; i < tv.size(); i++) begin
      drive(tv[i].ocs, tv[i].oad, tv[i].scs, tv[i].sad, tv[i].rok, tv[i].rdat);
      step();
      chk($sformatf("v%0d_rom_cs", i),   bus.rom_cs,   tv[i].ecs);
      chk($sformatf("v%0d_rom_addr", i), bus.rom_addr, tv[i].ead);
      chk($sformatf("v%0d_obj_ok", i),   bus.obj_ok,   tv[i].eook);
      chk($sformatf("v%0d_obj_data", i), bus.obj_data, tv[i].eod);
      chk($sformatf("v%0d_scr_ok", i),   bus.scr_ok,   tv[i].esok);
      chk($sformatf("v%0d_scr_data", i), bus.scr_data, tv[i].esd);
    end

    // Abort: obj drops in WAIT, pending scr is granted from the next IDLE.
    drive(1, 18'h0030, 1, 18'h0050, 0, 0);
    step(); chk("abort_addr0", bus.rom_addr, 18'h0030);
    step();
    bus.obj_cs = 1'b0;
    step();
    chk("abort_obj_ok", bus.obj_ok, 1'b0);
    chk("abort_obj_data", bus.obj_data, 32'h11111111);
    chk("abort_rom_cs", bus.rom_cs, 1'b1);
    step(); chk("abort_scr_grant", bus.rom_addr, 18'h0050);
    step();
    bus.rom_ok = 1'b1; bus.rom_data = 32'h5555AAAA;
    step(); chk("abort_scr_ok", bus.scr_ok, 1'b1); chk("abort_scr_data", bus.scr_data, 32'h5555AAAA);
    drive(0, 0, 0, 0, 0, 0);
    step();

    // Address change in WAIT: stale data refused, GUARD re-entered.
    drive(0, 0, 1, 18'h0100, 0, 0);
    step(); chk("readdr_addr0", bus.rom_addr, 18'h0100);
    step();
    bus.scr_addr = 18'h0101; bus.rom_ok = 1'b1; bus.rom_data = 32'hBAD00100;
    step();
    chk("readdr_addr1", bus.rom_addr, 18'h0101);
    chk("readdr_ok0", bus.scr_ok, 1'b0);
    chk("readdr_data_kept", bus.scr_data, 32'h5555AAAA);
    bus.rom_data = 32'h600D0101;
    step(); chk("readdr_guard_ok", bus.scr_ok, 1'b0);
    step(); chk("readdr_ok", bus.scr_ok, 1'b1); chk("readdr_data", bus.scr_data, 32'h600D0101);
    drive(0, 0, 0, 0, 0, 0);
    step();

    // After an obj-only completion, a tie goes to scr.
    drive(1, 18'h0200, 0, 0, 0, 0);
    step(); step();
    bus.rom_ok = 1'b1; bus.rom_data = 32'h02000200;
    step(); chk("tie2_obj_ok", bus.obj_ok, 1'b1);
    drive(0, 0, 0, 0, 0, 0);
    step();
    drive(1, 18'h0201, 1, 18'h0202, 0, 0);
    step(); chk("tie2_scr_first", bus.rom_addr, 18'h0202);
    step();

    // Reset while scr is in WAIT; obj stays pending and is re-granted.
    bus.scr_cs = 1'b0;
    #2 rst = 1'b1;
    #1 chk_all_zero("midrst");
    @(posedge clk);
    #1 rst = 1'b0;
    step(); chk("midrst_regrant_cs", bus.rom_cs, 1'b1); chk("midrst_regrant_addr", bus.rom_addr, 18'h0201);
    step();
    bus.rom_ok = 1'b1; bus.rom_data = 32'h0201ABCD;
    step(); chk("midrst_obj_ok", bus.obj_ok, 1'b1); chk("midrst_obj_data", bus.obj_data, 32'h0201ABCD);
    drive(0, 0, 0, 0, 0, 0);
    step(); step();

    // Random traffic: contract-following requesters, SDRAM whose rom_data/rom_ok
    // lag rom_addr by one cycle so a fresh address sees one stale beat.
    for (int r = 0; r < 2; r++) begin
      act[r] = 0; served[r] = 0; clr[r] = 0; age[r] = 0; cool[r] = 0; adr[r] = '0;
    end
    prev_addr = bus.rom_addr;
    for (int cyc = 0; cyc < 4000; cyc++) begin
      step();
      s_ok[0] = bus.obj_ok; s_dat[0] = bus.obj_data;
      s_ok[1] = bus.scr_ok; s_dat[1] = bus.scr_data;
      for (int r = 0; r < 2; r++) begin
        if (act[r]) age[r]++;
        if (clr[r] || !act[r]) begin
          chk($sformatf("rnd_ok_low_r%0d", r), s_ok[r], 1'b0);
        end else if (served[r]) begin
          chk($sformatf("rnd_ok_hold_r%0d", r), s_ok[r], 1'b1);
          chk($sformatf("rnd_data_hold_r%0d", r), s_dat[r], mem(adr[r]));
        end else if (s_ok[r]) begin
          chk($sformatf("rnd_latency_r%0d", r), age[r] >= 3, 1'b1);
          chk($sformatf("rnd_data_r%0d", r), s_dat[r], mem(adr[r]));
          served[r] = 1'b1;
        end else if (age[r] > 300) begin
          chk($sformatf("rnd_wait_bound_r%0d", r), s_ok[r], 1'b1);
          act[r] = 1'b0; cool[r] = 2;
        end
      end
      for (int r = 0; r < 2; r++) begin
        clr[r] = 1'b0;
        if (cool[r] > 0) begin
          cool[r]--;
        end else if (!act[r]) begin
          if ($urandom_range(0, 2) == 0) begin
            act[r] = 1'b1; served[r] = 1'b0; age[r] = 0;
            adr[r] = AW'($urandom_range(0, 15));
          end
        end else if (served[r]) begin
          case ($urandom_range(0, 3))
            0, 1: begin act[r] = 1'b0; clr[r] = 1'b1; cool[r] = 2; end
            2: begin
              adr[r] = adr[r] ^ AW'($urandom_range(1, 15));
              served[r] = 1'b0; age[r] = 0; clr[r] = 1'b1; cool[r] = 2;
            end
            default: ;
          endcase
        end else begin
          case ($urandom_range(0, 49))
            0: begin act[r] = 1'b0; clr[r] = 1'b1; cool[r] = 2; end
            1: begin adr[r] = adr[r] ^ AW'($urandom_range(1, 15)); age[r] = 0; cool[r] = 2; end
            default: ;
          endcase
        end
      end
      bus.obj_cs = act[0]; bus.obj_addr = adr[0];
      bus.scr_cs = act[1]; bus.scr_addr = adr[1];
      bus.rom_data = mem(prev_addr);
      bus.rom_ok = ($urandom_range(0, 2) != 0);
      prev_addr = bus.rom_addr;
    end

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
